// File: rtl/packet_disassembler.sv
// Reassembles 32-beat HDMI data-island packets into header/subpacket words.
// Define PACKET_DISASSEMBLER_ECC_CHECK_EN to build the BCH parity checkers.
module packet_disassembler (
    input  logic         clk_pixel,
    input  logic         reset,
    input  logic         data_island_period,
    input  logic [8:0]   packet_data,
    output logic [23:0]  header,
    output logic [223:0] sub,
    output logic         packet_valid,
    output logic         header_ecc_err,
    output logic [3:0]   sub_ecc_err,
    output logic [4:0]   counter
);

    logic [31:0]      hdr_work;
    logic [3:0][63:0] sub_work;
    logic [31:0]      hdr_next;
    logic [3:0][63:0] sub_next;
    logic             last_beat;

    assign last_beat = data_island_period && (counter == 5'd31);

    // Working words with the current beat merged in, so the c=31 beat's parity bits are visible.
    always_comb begin
        hdr_next = hdr_work;
        sub_next = sub_work;
        hdr_next[counter] = packet_data[0];
        for (int i = 0; i < 4; i++) begin
            sub_next[i][{counter, 1'b0}] = packet_data[1 + i];
            sub_next[i][{counter, 1'b1}] = packet_data[5 + i];
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            counter      <= 5'd0;
            hdr_work     <= '0;
            sub_work     <= '0;
            header       <= '0;
            sub          <= '0;
            packet_valid <= 1'b0;
        end else begin
            packet_valid <= last_beat;
            if (data_island_period) begin
                counter  <= counter + 5'd1;
                hdr_work <= hdr_next;
                sub_work <= sub_next;
            end else begin
                counter  <= 5'd0;
            end
            if (last_beat) begin
                header <= hdr_next[23:0];
                for (int i = 0; i < 4; i++) begin
                    sub[56*i +: 56] <= sub_next[i][55:0];
                end
            end
        end
    end

`ifdef PACKET_DISASSEMBLER_ECC_CHECK_EN
    logic [7:0]      hdr_ecc;
    logic [3:0][7:0] sub_ecc;
    logic [7:0]      hdr_ecc_next;
    logic [3:0][7:0] sub_ecc_next;

    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
    endfunction

    // Header covers beats 0..23; subpackets cover bit pairs from beats 0..27.
    always_comb begin
        hdr_ecc_next = hdr_ecc;
        sub_ecc_next = sub_ecc;
        if (counter < 5'd24) begin
            hdr_ecc_next = ecc_step(hdr_ecc, packet_data[0]);
        end
        if (counter < 5'd28) begin
            for (int i = 0; i < 4; i++) begin
                sub_ecc_next[i] = ecc_step(ecc_step(sub_ecc[i], packet_data[1 + i]),
                                           packet_data[5 + i]);
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hdr_ecc        <= '0;
            sub_ecc        <= '0;
            header_ecc_err <= 1'b0;
            sub_ecc_err    <= 4'd0;
        end else begin
            if (!data_island_period || last_beat) begin
                hdr_ecc <= '0;
                sub_ecc <= '0;
            end else begin
                hdr_ecc <= hdr_ecc_next;
                sub_ecc <= sub_ecc_next;
            end
            if (last_beat) begin
                header_ecc_err <= (hdr_ecc != hdr_next[31:24]);
                for (int i = 0; i < 4; i++) begin
                    sub_ecc_err[i] <= (sub_ecc[i] != sub_next[i][63:56]);
                end
            end
        end
    end
`else
    assign header_ecc_err = 1'b0;
    assign sub_ecc_err    = 4'd0;
`endif

endmodule

// File: tb/tb_packet_disassembler.sv
// Directed bench for packet_disassembler: BCH parity model, pulse scoreboard, counter tracking.
module tb_packet_disassembler;
    localparam int W = 253;
`ifdef PACKET_DISASSEMBLER_ECC_CHECK_EN
    localparam bit ECC_EN = 1'b1;
`else
    localparam bit ECC_EN = 1'b0;
`endif

    logic         clk_pixel = 1'b0;
    logic         reset;
    logic         data_island_period;
    logic [8:0]   packet_data;
    logic [23:0]  header;
    logic [223:0] sub;
    logic         packet_valid;
    logic         header_ecc_err;
    logic [3:0]   sub_ecc_err;
    logic [4:0]   counter;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [23:0]  last_hdr = '0;
    logic [223:0] last_sub = '0;

    packet_disassembler dut (
        .clk_pixel(clk_pixel), .reset(reset), .data_island_period(data_island_period),
        .packet_data(packet_data), .header(header), .sub(sub), .packet_valid(packet_valid),
        .header_ecc_err(header_ecc_err), .sub_ecc_err(sub_ecc_err), .counter(counter)
    );

    always #5 clk_pixel = ~clk_pixel;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bch_par(input logic [63:0] bits, input int n);
        logic [7:0] e = 8'h00;
        for (int k = 0; k < n; k++) e = (e >> 1) ^ ((e[0] ^ bits[k]) ? 8'h83 : 8'h00);
        return e;
    endfunction

    // Scoreboard: every pulse must match the oldest pending packet, on its predicted cycle.
    always @(negedge clk_pixel) begin
        if (packet_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("pulse_expected", 256'(exp_q.size()), 256'(1));
            end else begin
                logic [W-1:0] r;
                int ec;
                r  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("pulse_cycle", 256'(cyc), 256'(ec));
                check("header", 256'(header), 256'(r[252:229]));
                check("sub", 256'(sub), 256'(r[228:5]));
                check("header_ecc_err", 256'(header_ecc_err), 256'(r[4]));
                check("sub_ecc_err", 256'(sub_ecc_err), 256'(r[3:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic idle(input int n);
        data_island_period = 1'b0;
        packet_data = 9'd0;
        repeat (n) tick();
    endtask

    task automatic send_packet(input logic [23:0] h, input logic [223:0] s,
                               input logic [23:0] hflip, input logic [223:0] sflip);
        logic [31:0]  hw;
        logic [63:0]  sw [4];
        logic [23:0]  hr;
        logic [223:0] sr;
        logic         herr;
        logic [3:0]   serr;
        hr = h ^ hflip;
        sr = s ^ sflip;
        hw = {bch_par(64'(h), 24), hr};
        herr = ECC_EN && (bch_par(64'(hr), 24) != bch_par(64'(h), 24));
        for (int i = 0; i < 4; i++) begin
            sw[i] = {bch_par(64'(s[56*i +: 56]), 56), sr[56*i +: 56]};
            serr[i] = ECC_EN && (bch_par(64'(sr[56*i +: 56]), 56) != bch_par(64'(s[56*i +: 56]), 56));
        end
        for (int c = 0; c < 32; c++) begin
            check("counter", 256'(counter), 256'(c));
            packet_data[0] = hw[c];
            for (int i = 0; i < 4; i++) begin
                packet_data[1 + i] = sw[i][2*c];
                packet_data[5 + i] = sw[i][2*c + 1];
            end
            data_island_period = 1'b1;
            if (c == 31) begin
                exp_q.push_back({hr, sr, herr, serr});
                exp_cyc_q.push_back(cyc + 1);
            end
            tick();
        end
        last_hdr = hr;
        last_sub = sr;
    endtask

    task automatic send_partial(input int n);
        for (int c = 0; c < n; c++) begin
            check("counter", 256'(counter), 256'(c));
            packet_data = 9'($urandom_range(0, 511));
            data_island_period = 1'b1;
            tick();
        end
    endtask

    function automatic logic [223:0] rand_sub();
        logic [223:0] s;
        for (int k = 0; k < 7; k++) s[32*k +: 32] = 32'($urandom_range(0, 32'hFFFF_FFFF));
        return s;
    endfunction

    initial begin
        logic [223:0] acr;
        logic [223:0] sflip;
        reset = 1'b1;
        data_island_period = 1'b0;
        packet_data = 9'd0;
        repeat (2) tick();
        check("rst_counter", 256'(counter), 256'(0));
        check("rst_header", 256'(header), 256'(0));
        check("rst_sub", 256'(sub), 256'(0));
        check("rst_valid", 256'(packet_valid), 256'(0));
        check("rst_header_ecc_err", 256'(header_ecc_err), 256'(0));
        check("rst_sub_ecc_err", 256'(sub_ecc_err), 256'(0));
        reset = 1'b0;

        // All-zero packet straight out of reset.
        send_packet(24'h0, 224'h0, 24'h0, 224'h0);
        idle(2);

        // Audio clock regeneration packet, clean then with two corrupted bits.
        acr = {4{56'h00_0018_0000_1770}};
        send_packet(24'h000001, acr, 24'h0, 224'h0);
        idle(1);
        sflip = '0;
        sflip[56*2 + 40] = 1'b1;
        send_packet(24'h000001, acr, 24'h000020, sflip);
        idle(1);
        send_packet(24'h000001, acr, 24'h0, 224'h0);

        // Three packets with data_island_period held high throughout.
        idle(1);
        for (int p = 0; p < 3; p++) begin
            send_packet(24'($urandom_range(0, 24'hFF_FFFF)), rand_sub(), 24'h0, 224'h0);
        end

        // Island drops at c=17: nothing published, outputs held, counter reloads.
        send_partial(17);
        idle(1);
        check("drop_counter", 256'(counter), 256'(0));
        check("drop_hold_header", 256'(header), 256'(last_hdr));
        check("drop_hold_sub", 256'(sub), 256'(last_sub));
        idle(2);
        send_packet(24'($urandom_range(0, 24'hFF_FFFF)), rand_sub(), 24'h0, 224'h0);
        idle(1);

        // One-cycle reset at c=10 while the island is still active.
        send_partial(10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        data_island_period = 1'b0;
        check("mid_rst_counter", 256'(counter), 256'(0));
        check("mid_rst_header", 256'(header), 256'(0));
        check("mid_rst_sub", 256'(sub), 256'(0));
        check("mid_rst_valid", 256'(packet_valid), 256'(0));
        check("mid_rst_header_ecc_err", 256'(header_ecc_err), 256'(0));
        check("mid_rst_sub_ecc_err", 256'(sub_ecc_err), 256'(0));
        idle(2);
        send_packet(24'($urandom_range(0, 24'hFF_FFFF)), rand_sub(), 24'h0, 224'h0);
        idle(3);
        check("pending_pulses", 256'(exp_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
